// File: rtl/conv_bram_1d_ternary_pad.sv
// 1D ternary convolution between image and result BRAM banks: padding, dilation, stride,
// 2-bit packed weights, wide accumulation, optional ReLU and signed saturation.
module conv_bram_1d_ternary_pad #(
  parameter int DATA_WIDTH            = 8,
  parameter int IMG_W                 = 32,
  parameter int IMG_D                 = 4,
  parameter int FILTER_L              = 3,
  parameter int RESULT_D              = 4,
  parameter int STRIDE_W              = 1,
  parameter int DILATION              = 1,
  parameter int PAD_W                 = 0,
  parameter int RESULT_W              = (IMG_W + 2*PAD_W - DILATION*(FILTER_L-1) - 1)/STRIDE_W + 1,
  parameter int ACC_WIDTH             = DATA_WIDTH + $clog2(IMG_D*FILTER_L) + 1,
  parameter int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [2*RESULT_D*IMG_D*FILTER_L-1:0]      fil,
  input  logic                                      relu_en,
  input  logic                                      val_in,
  output logic                                      rdy_in,
  output logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0]       img_rdaddr,
  input  logic [DATA_WIDTH*IMG_D-1:0]               img_rddata,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddr,
  output logic [DATA_WIDTH*RESULT_D-1:0]            result_wrdata,
  output logic [RESULT_D-1:0]                       result_wren,
  output logic                                      done
);

  localparam int TW = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;
  localparam int XW = RESULT_RAM_ADDR_WIDTH;
  localparam int FW = 2*RESULT_D*IMG_D*FILTER_L;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TW-1:0] T_LAST = TW'(FILTER_L - 1);
  localparam logic [XW-1:0] X_LAST = XW'(RESULT_W - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2**(DATA_WIDTH-1)));

  logic [1:0]          state;
  logic [FW-1:0]       fil_q;
  logic                relu_q;
  logic [XW-1:0]       x_cnt;
  logic [TW-1:0]       t_cnt;

  // tap pipeline: attributes of the tap whose data is on img_rddata this cycle
  logic                p_vld, p_first, p_last, p_pad, p_final;
  logic [TW-1:0]       p_t;
  logic [XW-1:0]       p_x;

  logic signed [ACC_WIDTH-1:0] acc     [RESULT_D];
  logic signed [ACC_WIDTH-1:0] acc_nxt [RESULT_D];

  logic                              wren_q, wr_final_q;
  logic [XW-1:0]                     wraddr_q;
  logic [RESULT_D-1:0][DATA_WIDTH-1:0] wrdata_q;

  int                          src;
  logic                        tap_pad;
  logic [IMG_RAM_ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    src     = int'(x_cnt)*STRIDE_W + int'(t_cnt)*DILATION - PAD_W;
    tap_pad = (src < 0) || (src >= IMG_W);
    rd_addr = (state == S_RUN && !tap_pad) ? IMG_RAM_ADDR_WIDTH'(src) : '0;
  end

  assign img_rdaddr    = {IMG_D{rd_addr}};
  assign result_wraddr = {RESULT_D{wraddr_q}};
  assign result_wrdata = wrdata_q;
  assign result_wren   = {RESULT_D{wren_q}};
  assign rdy_in        = (state == S_IDLE);
  assign done          = (state == S_DONE);

  logic signed [ACC_WIDTH-1:0]  tap_sum, elem_ext;
  logic signed [DATA_WIDTH-1:0] elem;
  logic [1:0]                   w;

  always_comb begin
    tap_sum  = '0;
    elem_ext = '0;
    elem     = '0;
    w        = '0;
    for (int k = 0; k < RESULT_D; k++) begin
      tap_sum = '0;
      for (int d = 0; d < IMG_D; d++) begin
        elem     = $signed(img_rddata[d*DATA_WIDTH +: DATA_WIDTH]);
        elem_ext = ACC_WIDTH'(elem);
        w        = fil_q[2*((k*IMG_D + d)*FILTER_L + int'(p_t)) +: 2];
        if (!p_pad && w == 2'b01)      tap_sum = tap_sum + elem_ext;
        else if (!p_pad && w == 2'b11) tap_sum = tap_sum - elem_ext;
      end
      // first tap of an output loads, so consecutive outputs need no clear cycle
      acc_nxt[k] = p_first ? tap_sum : acc[k] + tap_sum;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] a,
                                                     input logic relu);
    if (relu && a < 0)    return '0;
    else if (a > SAT_MAX) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (a < SAT_MIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                  return a[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      fil_q  <= '0;
      relu_q <= 1'b0;
      x_cnt  <= '0;
      t_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (val_in) begin
          fil_q  <= fil;
          relu_q <= relu_en;
          x_cnt  <= '0;
          t_cnt  <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (t_cnt == T_LAST) begin
            t_cnt <= '0;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              state <= S_DRAIN;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        S_DRAIN: if (wr_final_q) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_vld   <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_pad   <= 1'b0;
      p_final <= 1'b0;
      p_t     <= '0;
      p_x     <= '0;
    end else begin
      p_vld   <= (state == S_RUN);
      p_first <= (t_cnt == '0);
      p_last  <= (t_cnt == T_LAST);
      p_pad   <= tap_pad;
      p_final <= (x_cnt == X_LAST) && (t_cnt == T_LAST);
      p_t     <= t_cnt;
      p_x     <= x_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RESULT_D; k++) acc[k] <= '0;
      wren_q     <= 1'b0;
      wr_final_q <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
    end else begin
      if (p_vld) begin
        for (int k = 0; k < RESULT_D; k++) acc[k] <= acc_nxt[k];
      end
      if (p_vld && p_last) begin
        wren_q     <= 1'b1;
        wr_final_q <= p_final;
        wraddr_q   <= p_x;
        for (int k = 0; k < RESULT_D; k++) wrdata_q[k] <= saturate(acc_nxt[k], relu_q);
      end else begin
        wren_q     <= 1'b0;
        wr_final_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_bram_1d_ternary_pad.sv
// Directed bench for conv_bram_1d_ternary_pad: four parameterisations share clock and reset.
module tb_conv_bram_1d_ternary_pad;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] val = '0;
  logic [7:0] img_val0 = 8'd1;
  int n_total = 0;
  int n_bad = 0;
  int sel = 0;

  // u0: defaults
  logic [95:0] fil0 = '0;
  logic        relu0 = 1'b0;
  logic        rdy0, done0;
  logic [19:0] ra0, wa0;
  logic [31:0] rd0, wd0;
  logic [3:0]  we0;
  // u1: PAD_W=1
  logic [95:0] fil1 = {48{2'b01}};
  logic        rdy1, done1;
  logic [19:0] ra1, wa1;
  logic [31:0] rd1, wd1;
  logic [3:0]  we1;
  // u2: IMG_D=1, DILATION=2, weights {+1,0,-1}
  logic [23:0] fil2 = {4{6'b110001}};
  logic        rdy2, done2;
  logic [4:0]  ra2;
  logic [19:0] wa2;
  logic [7:0]  rd2;
  logic [31:0] wd2;
  logic [3:0]  we2;
  // u3: STRIDE_W=2, FILTER_L=1, weight field 10
  logic [31:0] fil3 = {16{2'b10}};
  logic        rdy3, done3;
  logic [19:0] ra3;
  logic [15:0] wa3;
  logic [31:0] rd3, wd3;
  logic [3:0]  we3;

  conv_bram_1d_ternary_pad u0 (
    .clk(clk), .reset(reset), .fil(fil0), .relu_en(relu0), .val_in(val[0]), .rdy_in(rdy0),
    .img_rdaddr(ra0), .img_rddata(rd0), .result_wraddr(wa0), .result_wrdata(wd0),
    .result_wren(we0), .done(done0));

  conv_bram_1d_ternary_pad #(.PAD_W(1)) u1 (
    .clk(clk), .reset(reset), .fil(fil1), .relu_en(1'b0), .val_in(val[1]), .rdy_in(rdy1),
    .img_rdaddr(ra1), .img_rddata(rd1), .result_wraddr(wa1), .result_wrdata(wd1),
    .result_wren(we1), .done(done1));

  conv_bram_1d_ternary_pad #(.IMG_D(1), .DILATION(2)) u2 (
    .clk(clk), .reset(reset), .fil(fil2), .relu_en(1'b0), .val_in(val[2]), .rdy_in(rdy2),
    .img_rdaddr(ra2), .img_rddata(rd2), .result_wraddr(wa2), .result_wrdata(wd2),
    .result_wren(we2), .done(done2));

  conv_bram_1d_ternary_pad #(.STRIDE_W(2), .FILTER_L(1)) u3 (
    .clk(clk), .reset(reset), .fil(fil3), .relu_en(1'b0), .val_in(val[3]), .rdy_in(rdy3),
    .img_rdaddr(ra3), .img_rddata(rd3), .result_wraddr(wa3), .result_wrdata(wd3),
    .result_wren(we3), .done(done3));

  // image BRAM models: one-cycle read latency
  always @(posedge clk) begin
    rd0 <= {4{img_val0}};
    rd1 <= {4{8'd1}};
    rd2 <= {3'b000, ra2};
    rd3 <= {4{8'd7}};
  end

  logic       o_rdy, o_done;
  logic [3:0] o_wren;
  logic [4:0] o_addr [4];
  logic [7:0] o_dat  [4];

  always_comb begin
    o_rdy  = 1'b0;
    o_done = 1'b0;
    o_wren = '0;
    for (int k = 0; k < 4; k++) begin
      o_addr[k] = '0;
      o_dat[k]  = '0;
    end
    case (sel)
      0: begin
        o_rdy = rdy0; o_done = done0; o_wren = we0;
        for (int k = 0; k < 4; k++) begin o_addr[k] = wa0[k*5 +: 5]; o_dat[k] = wd0[k*8 +: 8]; end
      end
      1: begin
        o_rdy = rdy1; o_done = done1; o_wren = we1;
        for (int k = 0; k < 4; k++) begin o_addr[k] = wa1[k*5 +: 5]; o_dat[k] = wd1[k*8 +: 8]; end
      end
      2: begin
        o_rdy = rdy2; o_done = done2; o_wren = we2;
        for (int k = 0; k < 4; k++) begin o_addr[k] = wa2[k*5 +: 5]; o_dat[k] = wd2[k*8 +: 8]; end
      end
      default: begin
        o_rdy = rdy3; o_done = done3; o_wren = we3;
        for (int k = 0; k < 4; k++) begin o_addr[k] = {1'b0, wa3[k*4 +: 4]}; o_dat[k] = wd3[k*8 +: 8]; end
      end
    endcase
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept one job on instance inst and check every cycle until one past done.
  task automatic run_job(input int inst, input int r, input int f,
                         input int exp_mid, input int exp_edge, input bit pulse);
    int writes;
    int idx;
    bit wexp;
    sel = inst;
    @(negedge clk);
    chk("idle_rdy", o_rdy, 1);
    val[inst] = 1'b1;
    @(negedge clk);
    val[inst] = 1'b0;
    writes = 0;
    for (int n = 1; n <= r*f + 4; n++) begin
      wexp = (n >= f + 2) && (((n - f - 2) % f) == 0) && (((n - f - 2) / f) < r);
      idx  = (n - f - 2) / f;
      chk("rdy", o_rdy, (n == r*f + 4) ? 1 : 0);
      chk("done", o_done, (n == r*f + 3) ? 1 : 0);
      chk("wren", o_wren, wexp ? 15 : 0);
      if (o_wren != '0) writes++;
      if (wexp) begin
        for (int k = 0; k < 4; k++) begin
          chk("wraddr", o_addr[k], idx);
          chk("wrdata", $signed(o_dat[k]), (idx == 0 || idx == r - 1) ? exp_edge : exp_mid);
        end
      end
      val[inst] = (pulse && n == 20);
      @(negedge clk);
    end
    chk("nwrites", writes, r);
  endtask

  initial begin
    int writes;
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy0, 1);
    chk("rst_wren", we0, 0);
    chk("rst_done", done0, 0);
    chk("rst_wrdata", wd0, 0);
    chk("rst_wraddr", wa0, 0);
    chk("rst_rdaddr0", ra0, 0);
    chk("rst_rdaddr1", ra1, 0);
    reset = 1'b0;

    // all +1, image 1: 12 everywhere; val_in pulsed while busy
    fil0 = {48{2'b01}}; relu0 = 1'b0; img_val0 = 8'd1;
    run_job(0, 30, 3, 12, 12, 1'b1);
    // 1200 saturates high
    img_val0 = 8'd100;
    run_job(0, 30, 3, 127, 127, 1'b0);
    // -1200 with ReLU clamps to 0, without saturates low
    fil0 = {48{2'b11}}; relu0 = 1'b1;
    run_job(0, 30, 3, 0, 0, 1'b0);
    relu0 = 1'b0;
    run_job(0, 30, 3, -128, -128, 1'b0);

    run_job(1, 32, 3, 12, 8, 1'b0);
    run_job(2, 28, 3, -4, -4, 1'b0);
    run_job(3, 16, 1, 0, 0, 1'b0);

    // abort on the 10th write
    fil0 = {48{2'b01}}; img_val0 = 8'd1; sel = 0;
    @(negedge clk);
    val[0] = 1'b1;
    @(negedge clk);
    val[0] = 1'b0;
    writes = 0;
    hit = 1'b0;
    for (int n = 1; n <= 60 && !hit; n++) begin
      if (o_wren != '0) writes++;
      if (writes == 10) begin
        hit = 1'b1;
        reset = 1'b1;
        #1;
        chk("abort_wren", o_wren, 0);
        chk("abort_rdy", o_rdy, 1);
        chk("abort_done", o_done, 0);
      end else begin
        @(negedge clk);
      end
    end
    chk("abort_reached", hit, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    writes = 0;
    for (int n = 0; n < 100; n++) begin
      if (o_wren != '0 || o_done) writes++;
      @(negedge clk);
    end
    chk("post_abort_quiet", writes, 0);

    run_job(0, 30, 3, 12, 12, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_bram_1d_ternary_pad.md
Name: conv_bram_1d_ternary_pad

Overview:
- Next-generation 1D ternary convolution engine sitting between the image BRAM bank and the result BRAM bank.
- Adds zero padding, dilation and 2-bit packed ternary weights over the fixed-geometry predecessor.
- Adds wide accumulation with optional ReLU and signed saturation, and a done pulse for layer sequencing.
- All RESULT_D output channels compute in parallel from one shared image read stream; all IMG_D input channels are summed per tap per cycle.

Parameters:
- DATA_WIDTH, 8, signed image/result element width
- IMG_W, 32, input length
- IMG_D, 4, input channels
- FILTER_L, 3, taps per filter
- RESULT_D, 4, output channels (one filter each)
- STRIDE_W, 1, output stride
- DILATION, 1, tap spacing
- PAD_W, 0, zero elements padded on each side
- RESULT_W, (IMG_W+2*PAD_W-DILATION*(FILTER_L-1)-1)/STRIDE_W+1, derived output length
- ACC_WIDTH, DATA_WIDTH+$clog2(IMG_D*FILTER_L)+1, derived accumulator width
- IMG_RAM_ADDR_WIDTH, $clog2(IMG_W), derived
- RESULT_RAM_ADDR_WIDTH, $clog2(RESULT_W), derived

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fil  in  2*RESULT_D*IMG_D*FILTER_L  packed ternary weights; field index ((k*IMG_D+d)*FILTER_L+t); 01=+1, 11=-1, 00/10=0
- relu_en  in  1  ReLU before saturation; sampled with fil
- val_in  in  1  filter/job valid
- rdy_in  out  1  ready to accept a job
- img_rdaddr  out  IMG_RAM_ADDR_WIDTH*IMG_D  read address, replicated per input channel
- img_rddata  in  DATA_WIDTH*IMG_D  read data, valid exactly 1 cycle after address
- result_wraddr  out  RESULT_RAM_ADDR_WIDTH*RESULT_D  write address per output channel
- result_wrdata  out  DATA_WIDTH*RESULT_D  write data per output channel
- result_wren  out  RESULT_D  write enable per output channel
- done  out  1  one-cycle pulse after final write

Behaviour:
- Reset: FSM=IDLE; rdy_in=1; img_rdaddr=0; result_wraddr=0; result_wrdata=0; result_wren=0; done=0; accumulators cleared.
- Reset asserted mid-job aborts the job immediately; no further writes are issued.
- Handshake: job accepted on the cycle val_in&&rdy_in. fil and relu_en are registered internally at acceptance. rdy_in drops the next cycle and stays low until the cycle after done. val_in while busy is ignored.
- FSM: IDLE -> RUN on accept. RUN -> DRAIN after the last tap address of output RESULT_W-1 is issued. DRAIN -> DONE after the last write. DONE -> IDLE in one cycle; done=1 during DONE.
- RUN issues one tap per cycle: output x=0..RESULT_W-1, tap t=0..FILTER_L-1, in order.
- Source index per tap: s = x*STRIDE_W + t*DILATION - PAD_W, computed signed.
- If s<0 or s>=IMG_W, the tap is a padding tap: img_rdaddr holds 0 and the tap's contribution is forced to 0 regardless of img_rddata.
- Pipeline: tap data arrives 1 cycle after its address.
- Accumulate stage: acc_k += sum over d of w(k,d,t)*img[d], in signed ACC_WIDTH. Weight +1 adds, -1 subtracts, 0 adds nothing.
- On tap t=0 the accumulator loads rather than adds, so back-to-back outputs carry no bubble.
- Output stage registered one cycle after the last tap is accumulated:
  - If relu_en and acc<0, the value is 0.
  - Then saturate to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - result_wren = all ones (all channels together); result_wraddr = x on every channel.
- Latency: first write on cycle accept+FILTER_L+2. Subsequent writes follow every FILTER_L cycles. done is one cycle after the last write. Total job length is RESULT_W*FILTER_L+3 cycles after accept.
- FILTER_L=1 is legal: one write per cycle in steady state.
- result_wren is deasserted on all non-write cycles. result_wrdata holds its last value.
- A new val_in is accepted in the cycle done falls (IDLE). There is no overlap between jobs.

Test Plan:
- Defaults, all weights +1, image d-channel value = 1 everywhere: 30 writes at addresses 0..29, each value 12, done 93 cycles after accept, rdy_in low throughout the job.
- PAD_W=1, all weights +1, all image values 1: RESULT_W=32; addr 0 and addr 31 = 8 (one padding tap each), others = 12; no img_rdaddr outside 0..31.
- DILATION=2, IMG_D=1, weights {+1,0,-1}, image ramp img[i]=i: every output = -4; RESULT_W=28.
- Saturation: all weights +1, all image values 100: acc=1200 -> write 127. Then all weights -1 with relu_en=1 -> write 0; with relu_en=0 -> write -128.
- Handshake/abort: pulse val_in while busy -> ignored, output count unchanged. Assert reset at the 10th write cycle -> result_wren=0 and rdy_in=1 that cycle. A fresh job completes correctly afterwards.
- STRIDE_W=2, FILTER_L=1, weight field 10: RESULT_W=16, all results 0; writes on consecutive cycles, addresses 0..15.
